stream_mux_rr: RTL and testbench

//  N-to-1 registered stream multiplexer with valid/ready handshake per channel and

---
 rtl/stream_mux_rr_pkg.sv | 12 +
 rtl/stream_mux_rr_if.sv | 25 ++
 rtl/stream_mux_rr_arbiter.sv | 36 +++
 rtl/stream_mux_rr.sv | 85 ++++++++
 tb/tb_stream_mux_rr.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the N:1 registered stream multiplexer.
package stream_mux_pkg;

  localparam int MODE_RR   = 0;
  localparam int MODE_PRIO = 1;

  // Select width never collapses to zero, so N=2 still gets a 1-bit index.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake and data bundle between N producers, the mux, and one consumer.
interface stream_mux_rr_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SELW = stream_mux_pkg::sel_w(N);

  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Purpose: pick one requester, scanning upward from ptr (en=1) or from index 0 (en=0).
// Latency: purely combinational.
// Backpressure: none; caller qualifies the grant with its own load condition.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = sel_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] idx
);

  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = en ? (int'(ptr) + k) : k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = SELW'(cand);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Purpose: N:1 stream mux with internal round-robin or fixed-priority arbitration.
// Latency: one cycle from input handshake to out_* (single output register).
// Backpressure: in_ready all low while the output register is full and not draining.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  parameter  int MODE = MODE_RR,
  localparam int SELW = sel_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  stream_mux_rr_if.slave  bus
);

  logic            load;
  logic            any_req;
  logic [N-1:0]    grant;
  logic [SELW-1:0] idx;
  logic [W-1:0]    sel_data;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_sel_q,   out_sel_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  rr_arbiter #(.N(N)) u_arb (
    .req   (bus.in_valid),
    .ptr   (ptr_q),
    .en    (MODE == MODE_RR),
    .grant (grant),
    .idx   (idx)
  );

  // Register can take a new word when empty or when its current word leaves this cycle.
  assign load    = ~out_valid_q | bus.out_ready;
  assign any_req = |bus.in_valid;

  assign bus.in_ready  = load ? (grant & bus.in_valid) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == SELW'(i)) sel_data = bus.in_data[i*W +: W];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (any_req) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_sel_d   = idx;
        if (MODE == MODE_RR) begin
          ptr_d = (idx == SELW'(N - 1)) ? '0 : idx + SELW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a round-robin and a fixed-priority instance share stimulus.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = sel_w(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.N(N), .W(W)) rr_if ();
  stream_mux_rr_if #(.N(N), .W(W)) pr_if ();

  stream_mux_rr #(.N(N), .W(W), .MODE(MODE_RR))   u_rr (.clk(clk), .rst(rst), .bus(rr_if));
  stream_mux_rr #(.N(N), .W(W), .MODE(MODE_PRIO)) u_pr (.clk(clk), .rst(rst), .bus(pr_if));

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = round-robin instance, 1 = fixed priority.
  int mv[2];
  int md[2];
  int ms[2];
  int mp[2];

  typedef struct {
    logic [N-1:0]    v;
    logic [N*W-1:0]  d;
    logic            ordy;
    logic [N-1:0]    rdy;
    logic            ov;
    logic [W-1:0]    od;
    logic [SELW-1:0] os;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_grant(input int m, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m == 0) ? (mp[m] + k) % N : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_rdy(input int m, input logic [N-1:0] v, input logic ordy);
    logic [N-1:0] r;
    int g;
    r = '0;
    g = m_grant(m, v);
    if ((mv[m] == 0 || ordy) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; md[m] = 0; ms[m] = 0; mp[m] = 0;
    end
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy,
                       output logic [N-1:0] rdy_rr, output logic [N-1:0] rdy_pr);
    logic [N-1:0] er0, er1;
    rr_if.in_valid = v; rr_if.in_data = d; rr_if.out_ready = ordy;
    pr_if.in_valid = v; pr_if.in_data = d; pr_if.out_ready = ordy;
    #1;
    rdy_rr = rr_if.in_ready;
    rdy_pr = pr_if.in_ready;
    er0 = m_rdy(0, v, ordy);
    er1 = m_rdy(1, v, ordy);
    chk("rr in_ready", rdy_rr, er0);
    chk("pr in_ready", rdy_pr, er1);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      int g;
      g = m_grant(m, v);
      if (mv[m] == 0 || ordy) begin
        if (g >= 0) begin
          mv[m] = 1;
          md[m] = int'(d[g*W +: W]);
          ms[m] = g;
          if (m == 0) mp[m] = (g + 1) % N;
        end else begin
          mv[m] = 0;
        end
      end
    end
    @(negedge clk);
    chk("rr out_valid", rr_if.out_valid, mv[0]);
    chk("rr out_data",  rr_if.out_data,  md[0]);
    chk("rr out_sel",   rr_if.out_sel,   ms[0]);
    chk("pr out_valid", pr_if.out_valid, mv[1]);
    chk("pr out_data",  pr_if.out_data,  md[1]);
    chk("pr out_sel",   pr_if.out_sel,   ms[1]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r_rr, r_pr;

    // Fairness rows from reset, then single channel, wrap/skip, backpressure.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{4'hF, 32'h1312_1110, 1'b1, 4'(1 << (i % 4)), 1'b1, 8'(8'h10 + i % 4), 2'(i % 4)};
    tbl[8]  = '{4'b0100, 32'h003C_0000, 1'b1, 4'b0100, 1'b1, 8'h3C, 2'd2};
    tbl[9]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h3C, 2'd2};
    tbl[10] = '{4'b0011, 32'h0000_2221, 1'b1, 4'b0001, 1'b1, 8'h21, 2'd0};
    tbl[11] = '{4'b0011, 32'h0000_2221, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[12] = '{4'b0010, 32'h0000_1100, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[13] = '{4'b1111, 32'h1312_1110, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tbl[14] = '{4'b1111, 32'h1312_1110, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tbl[15] = '{4'b1111, 32'h1312_1110, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tbl[16] = '{4'b1111, 32'h1312_1110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[17] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    tbl[18] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h12, 2'd2};

    rst = 1'b1;
    rr_if.in_valid = '0; rr_if.in_data = '0; rr_if.out_ready = 1'b0;
    pr_if.in_valid = '0; pr_if.in_data = '0; pr_if.out_ready = 1'b0;
    model_reset();
    #1;
    chk("reset out_valid", rr_if.out_valid, 0);
    chk("reset out_data",  rr_if.out_data,  0);
    chk("reset out_sel",   rr_if.out_sel,   0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].ordy, r_rr, r_pr);
      chk($sformatf("vec%0d in_ready", i),  r_rr,            tbl[i].rdy);
      chk($sformatf("vec%0d out_valid", i), rr_if.out_valid, tbl[i].ov);
      chk($sformatf("vec%0d out_data", i),  rr_if.out_data,  tbl[i].od);
      chk($sformatf("vec%0d out_sel", i),   rr_if.out_sel,   tbl[i].os);
    end

    // Fixed priority: channel 1 always beats channel 3.
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1010, 32'hDD00_CC00, 1'b1, r_rr, r_pr);
      chk("prio in_ready3", r_pr[3],        0);
      chk("prio out_sel",   pr_if.out_sel,  1);
      chk("prio out_data",  pr_if.out_data, 8'hCC);
    end

    // Reset while a word is held: it must vanish immediately and ptr restart at 0.
    cycle(4'b0001, 32'h0000_00A5, 1'b1, r_rr, r_pr);
    chk("midrst held data", rr_if.out_data, 8'hA5);
    rst = 1'b1;
    #1;
    chk("midrst out_valid", rr_if.out_valid, 0);
    chk("midrst out_data",  rr_if.out_data,  0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(4'b1111, 32'h1312_1110, 1'b1, r_rr, r_pr);
    chk("midrst first grant", rr_if.out_sel, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0]   v;
      logic [N*W-1:0] d;
      logic           o;
      v = N'($urandom_range(0, 15));
      d = $urandom;
      o = ($urandom_range(0, 3) != 0);
      cycle(v, d, o, r_rr, r_pr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
